regfile_2r1w_param: RTL and testbench

// - Parametrised 2-read/1-write register file; generalises the fixed 16x16 register file to any width/depth.
// - Adds byte-lane write enables, registered reads, optional write-to-read bypass, optional hardwired-zero

---
 rtl/regfile_2r1w_param.sv | 152 +++++++++++++++
 tb/tb_regfile_2r1w_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_param.sv
// rtl/regfile_2r1w_param.sv - parametrised 2-read/1-write register file with byte lanes and clear sweep
//
// Purpose:
//   Operand storage with DEPTH = 2**ADDR_W entries of DATA_W bits. It has one write port
//   with byte-lane enables and two independent registered read ports. Two options are set
//   by parameter: same-cycle write forwarding (BYPASS) and a hardwired-zero entry 0
//   (ZERO_REG). A background sweep clears every entry, one per cycle, without needing a reset.
//
// Ports:
//   clk_i, rst_ni          clock and synchronous active-low reset
//   wr_en_i, wr_addr_i,    write request, address, byte-lane enables and data
//   wr_be_i, wr_data_i
//   wr_ack_o               write accepted this cycle (combinational; low while sweeping)
//   rd1_addr_i/rd1_data_o  read port 1, one-cycle latency
//   rd2_addr_i/rd2_data_o  read port 2, one-cycle latency
//   clr_i                  start a clear sweep (only sampled while idle)
//   busy_o                 sweep in progress
//   done_o                 single-cycle pulse after the last entry is cleared
module regfile_2r1w_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W/8-1:0]   wr_be_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  output logic                  wr_ack_o,
  input  logic [ADDR_W-1:0]     rd1_addr_i,
  output logic [DATA_W-1:0]     rd1_data_o,
  input  logic [ADDR_W-1:0]     rd2_addr_i,
  output logic [DATA_W-1:0]     rd2_data_o,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;

  logic                busy;
  logic                wr_ack;
  logic                wr_apply;
  logic [DATA_W-1:0]   be_mask;
  logic [DATA_W-1:0]   wr_merged;

  assign busy     = (state_q == S_SWEEP);
  assign wr_ack   = wr_en_i & ~busy;
  // A write to entry 0 with ZERO_REG set is acknowledged but never stored.
  assign wr_apply = wr_ack & ~(ZERO_REG && (wr_addr_i == '0));

  always_comb begin
    be_mask = '0;
    for (int k = 0; k < NB; k++) begin
      be_mask[8*k +: 8] = {8{wr_be_i[k]}};
    end
  end

  // Value the addressed entry will hold after this edge; this value is also forwarded on bypass.
  assign wr_merged = (mem_q[wr_addr_i] & ~be_mask) | (wr_data_i & be_mask);

  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
    if (ZERO_REG && (a == '0)) begin
      return '0;
    end else if (BYPASS && wr_apply && (a == wr_addr_i)) begin
      return wr_merged;
    end else begin
      return mem_q[a];
    end
  endfunction

  always_comb begin
    rd1_d = read_val(rd1_addr_i);
    rd2_d = read_val(rd2_addr_i);
  end

  // Sweep FSM: one entry is cleared per cycle, so busy lasts exactly DEPTH cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clr_i) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  // Writes are blocked while busy, so the sweep and the write port never target the array together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_apply) begin
      mem_q[wr_addr_i] <= wr_merged;
    end
  end

  assign wr_ack_o   = wr_ack;
  assign rd1_data_o = rd1_q;
  assign rd2_data_o = rd2_q;
  assign busy_o     = busy;
  assign done_o     = done_q;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// tb/tb_regfile_2r1w_param.sv - directed self-checking bench for regfile_2r1w_param
module tb_regfile_2r1w_param;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic [3:0]  rd1_addr, rd2_addr;
  logic        clr;

  logic        ack_a, busy_a, done_a;
  logic [15:0] rd1_a, rd2_a;
  logic        ack_b, busy_b, done_b;
  logic [15:0] rd1_b, rd2_b;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int n;

  always #5 clk = ~clk;

  // Default configuration: bypass on, no zero register.
  regfile_2r1w_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .wr_ack_o(ack_a), .rd1_addr_i(rd1_addr), .rd1_data_o(rd1_a),
    .rd2_addr_i(rd2_addr), .rd2_data_o(rd2_a), .clr_i(clr), .busy_o(busy_a), .done_o(done_a)
  );

  // Alternate configuration: no bypass, hardwired-zero entry 0.
  regfile_2r1w_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .wr_ack_o(ack_b), .rd1_addr_i(rd1_addr), .rd1_data_o(rd1_b),
    .rd2_addr_i(rd2_addr), .rd2_data_o(rd2_b), .clr_i(clr), .busy_o(busy_b), .done_o(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Counts busy cycles of dut_a, bounded so a stuck FSM cannot hang the run.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = 2'b11; wr_data = '0;
    rd1_addr = '0; rd2_addr = '0; clr = 1'b0;
    repeat (10) tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rd1", rd1_a, 16'h0000);
    chk("rst_rd2_b", rd2_b, 16'h0000);

    rst_ni = 1'b1;
    rd1_addr = 4'd6; rd2_addr = 4'd0;
    tick();
    chk("init_rd1_a6", rd1_a, 16'h0000);
    chk("init_rd2_a0", rd2_a, 16'h0000);

    // Basic write; the read is issued in the same cycle as the write.
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h0019; wr_be = 2'b11;
    #1;
    chk("wr_ack_a", ack_a, 1);
    tick();
    wr_en = 1'b0;
    chk("wr6_bypass_a", rd1_a, 16'h0019);
    chk("wr6_nobypass_b", rd1_b, 16'h0000);
    tick();
    chk("rd6_a", rd1_a, 16'h0019);
    chk("rd6_b", rd1_b, 16'h0019);

    // Byte-lane merge, with and without bypass.
    rd1_addr = 4'd5; rd2_addr = 4'd5;
    write(4'd3, 16'hAABB, 2'b11);
    rd1_addr = 4'd3; rd2_addr = 4'd3;
    write(4'd3, 16'h1234, 2'b01);
    chk("be_bypass_rd1_a", rd1_a, 16'hAA34);
    chk("be_bypass_rd2_a", rd2_a, 16'hAA34);
    chk("be_nobypass_rd1_b", rd1_b, 16'hAABB);
    tick();
    chk("be_next_rd1_b", rd1_b, 16'hAA34);

    // Zero-lane write is acked but changes nothing.
    write(4'd3, 16'hFFFF, 2'b00);
    tick();
    chk("be00_rd1_a", rd1_a, 16'hAA34);

    // Entry 0: a normal register in dut_a, hardwired zero in dut_b.
    rd1_addr = 4'd0; rd2_addr = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0040; wr_be = 2'b11;
    #1;
    chk("zero_ack_b", ack_b, 1);
    tick();
    wr_en = 1'b0;
    chk("zero_rd1_a", rd1_a, 16'h0040);
    chk("zero_rd1_b", rd1_b, 16'h0000);
    tick();
    chk("zero_rd2_a", rd2_a, 16'h0040);
    chk("zero_rd2_b", rd2_b, 16'h0000);

    // Fill with addr+1, then sweep.
    for (int i = 0; i < 16; i++) write(4'(i), 16'(i + 1), 2'b11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sweep_busy_start", busy_a, 1);
    chk("sweep_busy_b", busy_b, 1);
    rd1_addr = 4'd15;
    n = 1;
    tick();
    chk("sweep_rd_unswept", rd1_a, 16'h0010);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hFFFF; wr_be = 2'b11;
    #1;
    chk("sweep_wr_ack", ack_a, 0);
    tick();
    wr_en = 1'b0;
    n = 2;
    while (busy_a === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("sweep_len", 32'(n), 16);
    chk("sweep_done_a", done_a, 1);
    chk("sweep_done_b", done_b, 1);
    tick();
    chk("sweep_done_clr", done_a, 0);
    for (int i = 0; i < 16; i++) begin
      rd1_addr = 4'(i); rd2_addr = 4'(15 - i);
      tick();
      chk($sformatf("swept_rd1_a_%0d", i), rd1_a, 16'h0000);
      chk($sformatf("swept_rd2_b_%0d", i), rd2_b, 16'h0000);
    end

    // Reset during a sweep abandons it and clears everything.
    write(4'd12, 16'h5555, 2'b11);
    rd1_addr = 4'd12;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    chk("midsweep_busy", busy_a, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_rd1", rd1_a, 16'h0000);
    tick();
    chk("midrst_entry12", rd1_a, 16'h0000);

    // Write and clear together in idle: write lands, then the sweep clears it.
    rd1_addr = 4'd4;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0777; wr_be = 2'b11; clr = 1'b1;
    #1;
    chk("clrwr_ack", ack_a, 1);
    tick();
    wr_en = 1'b0; clr = 1'b0;
    chk("clrwr_rd_bypass", rd1_a, 16'h0777);
    count_busy(n);
    chk("restart_len", 32'(n), 16);
    chk("restart_done", done_a, 1);
    tick();
    chk("restart_entry4", rd1_a, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
